// File: rtl/psum_accumulator.sv
// psum_accumulator: sums signed partial-sum vectors over N passes and hands each finished vector to the scaler
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_num_passes      passes per output vector (0 acts as 1), sampled on a group's first beat
//   clear_i             flush the in-progress group and the pending output
//   psum_i/_valid_i/ready_o  incoming partial-sum vector handshake (lane i at [i*PSUM_WIDTH +: PSUM_WIDTH])
//   wx_o/_valid_o/ready_i    saturated accumulated vector handshake toward the scaler
//   busy_o              a group is partially accumulated
module psum_accumulator #(
   parameter int NUM_ELEMENTS  = 4,
   parameter int PSUM_WIDTH    = 16,
   parameter int ELEMENT_WIDTH = 20,
   parameter int PASS_WIDTH    = 8
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [PASS_WIDTH-1:0]                 cfg_num_passes,
   input  logic                                  clear_i,
   input  logic [NUM_ELEMENTS*PSUM_WIDTH-1:0]    psum_i,
   input  logic                                  psum_valid_i,
   output logic                                  psum_ready_o,
   output logic [NUM_ELEMENTS*ELEMENT_WIDTH-1:0] wx_o,
   output logic                                  wx_valid_o,
   input  logic                                  wx_ready_i,
   output logic                                  busy_o
);
   localparam int NE = NUM_ELEMENTS;
   localparam int PW = PSUM_WIDTH;
   localparam int EW = ELEMENT_WIDTH;
   logic [PASS_WIDTH-1:0] pass_cnt_q, pass_cnt_d, n_passes_q, n_passes_d, eff_passes;
   logic [NE*EW-1:0] acc_q, acc_d, wx_q, wx_d, sat;
   logic [NE-1:0][EW:0] sum_ext;
   logic wx_valid_q, wx_valid_d, first, last, accept;
   always_comb begin
      first = pass_cnt_q == '0;
      eff_passes = cfg_num_passes == '0 ? PASS_WIDTH'(1) : cfg_num_passes;
      // A first beat is judged against the live config, later beats against the latched count
      last = first ? eff_passes == PASS_WIDTH'(1) : pass_cnt_q == n_passes_q - PASS_WIDTH'(1);
   end
   // Only a last beat needs the output slot, so only it can be held off
   assign psum_ready_o = !(last && wx_valid_q && !wx_ready_i);
   assign accept = psum_valid_i && psum_ready_o;
   always_comb begin
      sum_ext = '0;
      sat = '0;
      for (int i = 0; i < NE; i++) begin
         sum_ext[i] = (first ? '0 : {acc_q[i*EW+EW-1], acc_q[i*EW +: EW]})
                    + {{(EW+1-PW){psum_i[i*PW+PW-1]}}, psum_i[i*PW +: PW]};
         // Top two bits disagree means the EW-bit range was left: clamp toward the true sign
         sat[i*EW +: EW] = sum_ext[i][EW] != sum_ext[i][EW-1] ?
                           {sum_ext[i][EW], {(EW-1){~sum_ext[i][EW]}}} : sum_ext[i][EW-1:0];
      end
   end
   always_comb begin
      pass_cnt_d = pass_cnt_q;
      n_passes_d = n_passes_q;
      acc_d = acc_q;
      wx_d = wx_q;
      wx_valid_d = wx_valid_q && !wx_ready_i;
      if (accept && last) begin
         wx_d = sat;
         wx_valid_d = 1'b1;
         pass_cnt_d = '0;
      end else if (accept) begin
         acc_d = sat;
         pass_cnt_d = pass_cnt_q + PASS_WIDTH'(1);
         n_passes_d = first ? eff_passes : n_passes_q;
      end
      if (clear_i) begin
         pass_cnt_d = '0;
         n_passes_d = n_passes_q;
         acc_d = acc_q;
         wx_d = wx_q;
         wx_valid_d = 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pass_cnt_q <= '0;
         n_passes_q <= PASS_WIDTH'(1);
         acc_q <= '0;
         wx_q <= '0;
         wx_valid_q <= 1'b0;
      end else begin
         pass_cnt_q <= pass_cnt_d;
         n_passes_q <= n_passes_d;
         acc_q <= acc_d;
         wx_q <= wx_d;
         wx_valid_q <= wx_valid_d;
      end
   end
   assign wx_o = wx_q;
   assign wx_valid_o = wx_valid_q;
   assign busy_o = pass_cnt_q != '0;
endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator: directed cycle-vector bench for psum_accumulator (lanes 0/2 carry p0, lanes 1/3 carry p1)
module tb_psum_accumulator;
   typedef struct {
      logic r;
      logic [7:0] cfg;
      logic v, clr, rdy;
      int p0, p1;
      logic erdy, ewv, ebusy, chk;
      int w0, w1;
   } vec_t;
   logic clk = 1'b0;
   logic rst, clear_i, psum_valid_i, psum_ready_o, wx_valid_o, wx_ready_i, busy_o;
   logic [7:0] cfg_num_passes;
   logic [63:0] psum_i;
   logic [79:0] wx_o;
   int n_vec = 0;
   int n_miss = 0;
   vec_t tbl[$];
   always #5 clk = ~clk;
   psum_accumulator dut (
      .clk(clk), .rst(rst), .cfg_num_passes(cfg_num_passes), .clear_i(clear_i),
      .psum_i(psum_i), .psum_valid_i(psum_valid_i), .psum_ready_o(psum_ready_o),
      .wx_o(wx_o), .wx_valid_o(wx_valid_o), .wx_ready_i(wx_ready_i), .busy_o(busy_o)
   );
   function automatic vec_t mk(logic r, logic [7:0] c, logic v, logic cl, logic rd, int p0, int p1,
                               logic er, logic ewv, logic eb, logic ck, int w0, int w1);
      mk = '{r, c, v, cl, rd, p0, p1, er, ewv, eb, ck, w0, w1};
   endfunction
   task automatic apply(input vec_t t);
      int g;
      @(negedge clk);
      rst = t.r;
      cfg_num_passes = t.cfg;
      psum_valid_i = t.v;
      clear_i = t.clr;
      wx_ready_i = t.rdy;
      psum_i = {t.p1[15:0], t.p0[15:0], t.p1[15:0], t.p0[15:0]};
      #1;
      n_vec++;
      if (psum_ready_o !== t.erdy) begin
         n_miss++;
         $display("FAIL vec %0d psum_ready: got %b want %b", n_vec, psum_ready_o, t.erdy);
      end
      @(posedge clk);
      #1;
      if (wx_valid_o !== t.ewv) begin
         n_miss++;
         $display("FAIL vec %0d wx_valid: got %b want %b", n_vec, wx_valid_o, t.ewv);
      end
      if (busy_o !== t.ebusy) begin
         n_miss++;
         $display("FAIL vec %0d busy: got %b want %b", n_vec, busy_o, t.ebusy);
      end
      if (t.chk) for (int l = 0; l < 4; l++) begin
         g = $signed(wx_o[l*20 +: 20]);
         if (g != ((l % 2) ? t.w1 : t.w0)) begin
            n_miss++;
            $display("FAIL vec %0d wx lane%0d: got %0d want %0d", n_vec, l, g, (l % 2) ? t.w1 : t.w0);
         end
      end
   endtask
   initial begin
      rst = 1'b1;
      clear_i = 1'b0;
      psum_valid_i = 1'b0;
      wx_ready_i = 1'b1;
      cfg_num_passes = 8'd1;
      psum_i = '0;
      repeat (2) @(posedge clk);
      // reset state, then reset in the middle of a group
      tbl.push_back(mk(0, 3, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 3, 1, 0, 1, 50, -50, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 3, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 3, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 1, 1, 0, 1, 7, 7, 1, 1, 0, 1, 7, 7));
      tbl.push_back(mk(0, 3, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
      // N=3 basic accumulate; cfg change on the last beat must be ignored
      tbl.push_back(mk(0, 3, 1, 0, 1, 100, 1, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 3, 1, 0, 1, -30, 2, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 1, 5, 3, 1, 1, 0, 1, 75, 6));
      tbl.push_back(mk(0, 3, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
      // N=0 and N=1 pass straight through
      tbl.push_back(mk(0, 0, 1, 0, 1, -9, 11, 1, 1, 0, 1, -9, 11));
      tbl.push_back(mk(0, 0, 1, 0, 1, 12, -13, 1, 1, 0, 1, 12, -13));
      tbl.push_back(mk(0, 1, 1, 0, 1, -1, 32767, 1, 1, 0, 1, -1, 32767));
      tbl.push_back(mk(0, 3, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
      // saturation at both rails over 20 passes
      for (int k = 0; k < 20; k++)
         tbl.push_back(mk(0, 20, 1, 0, 1, -32768, 32767, 1, k == 19, k != 19, k == 19, -524288, 524287));
      tbl.push_back(mk(0, 20, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
      // cross the rail at beat 17, then come back: result is relative to the clamp
      for (int k = 0; k < 20; k++)
         tbl.push_back(mk(0, 20, 1, 0, 1, k < 17 ? 32767 : -32768, k < 17 ? -32768 : 32767,
                          1, k == 19, k != 19, k == 19, 425983, -425987));
      tbl.push_back(mk(0, 2, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
      // backpressure with N=2
      tbl.push_back(mk(0, 2, 1, 0, 1, 10, 20, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 2, 1, 0, 0, 1, 2, 1, 1, 0, 1, 11, 22));
      tbl.push_back(mk(0, 2, 1, 0, 0, 3, 4, 1, 1, 1, 1, 11, 22));
      tbl.push_back(mk(0, 2, 1, 0, 0, 5, 6, 0, 1, 1, 1, 11, 22));
      tbl.push_back(mk(0, 2, 1, 0, 0, 5, 6, 0, 1, 1, 1, 11, 22));
      tbl.push_back(mk(0, 2, 1, 0, 1, 5, 6, 1, 1, 0, 1, 8, 10));
      tbl.push_back(mk(0, 2, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
      // clear with N=4 discards the in-flight beat, then a clean group of 1..4
      tbl.push_back(mk(0, 4, 1, 0, 1, 1, 1, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 4, 1, 0, 1, 1, 1, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 4, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4, 1, 0, 1, 1, 10, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 4, 1, 0, 1, 2, 20, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 4, 1, 0, 1, 3, 30, 1, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 4, 1, 0, 1, 4, 40, 1, 1, 0, 1, 10, 100));
      // clear also drops a stalled output
      tbl.push_back(mk(0, 4, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 4, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
      foreach (tbl[k]) apply(tbl[k]);
      // back-to-back N=1 stream: one output per cycle, in order
      for (int i = 0; i < 16; i++)
         apply(mk(0, 1, 1, 0, 1, i * 37 - 200, -i * 1000, 1, 1, 0, 1, i * 37 - 200, -i * 1000));
      apply(mk(0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Accumulates signed partial-sum vectors from the PE array over a configurable number of passes (input-channel tiles) and presents each completed sum vector, with valid/ready handshaking, as the `wx` input of the output scaler. It is the producer end of the accumulator-to-scaler interface. The scaler consumes one `numElements`-wide, `elementWidth`-bit vector per completed output position.

## Interface
- `numElements`, 4: lanes per vector (one per PE column).
- `psumWidth`, 16: signed width of each incoming partial sum.
- `elementWidth`, 20: signed width of the accumulated output; must be ≥ `psumWidth`.
- `passWidth`, 8: width of the pass-count configuration.

Ports:
- `clk`, input, 1: clock. One clock domain.
- `rst`, input, 1: reset, synchronous, active-high.
- `cfg_num_passes`, input, `passWidth`: partial sums per output vector. 0 is treated as 1. Sampled only when `pass_cnt == 0`.
- `clear_i`, input, 1: synchronous flush of the in-progress group and the output register.
- `psum_i`, input, `numElements` × `psumWidth`: signed partial-sum vector.
- `psum_valid_i`, input, 1: `psum_i` valid.
- `psum_ready_o`, output, 1: accumulator can accept `psum_i`.
- `wx_o`, output, `numElements` × `elementWidth`: signed accumulated vector to the output scaler.
- `wx_valid_o`, output, 1: `wx_o` valid.
- `wx_ready_i`, input, 1: scaler accepts `wx_o`.
- `busy_o`, output, 1: high when a group is partially accumulated (`pass_cnt != 0`).

## Operation
- State:
  - `pass_cnt` (`passWidth`).
  - Latched `n_passes`.
  - Per-lane accumulator `acc[i]` (`elementWidth`, signed).
  - Output register `wx_o` plus `wx_valid_o`.
- Input beat accepted when `psum_valid_i && psum_ready_o`.
- Per-lane `sum[i]`, computed at `elementWidth+1` bits:
  - First beat (`pass_cnt == 0`): `sext(psum_i[i])`.
  - Otherwise: `acc[i] + sext(psum_i[i])`.
  - Then saturated to the signed `elementWidth` range [−2^(EW−1), 2^(EW−1)−1]. No wrap-around.
- Non-last accepted beat:
  - `acc[i] <= sum[i]`, `pass_cnt <= pass_cnt + 1`.
  - On a first beat, `n_passes <= max(cfg_num_passes, 1)`.
- Last beat (`pass_cnt == n_passes − 1`, or a first beat with effective passes = 1):
  - `wx_o[i] <= sum[i]`, `wx_valid_o <= 1`, `pass_cnt <= 0`.
  - `acc` is don't-care after this beat; the next first beat overwrites it.
- `psum_ready_o = !(is_last_beat && wx_valid_o && !wx_ready_i)`.
  - Non-last beats are always accepted, even while the output is stalled.
  - A last beat is accepted only if the output slot is empty or being drained in the same cycle.
  - Combinational dependence on `wx_ready_i` is allowed. There is no combinational path from `psum_valid_i`.
- Output handshake:
  - `wx_o` and `wx_valid_o` are held stable while `wx_valid_o && !wx_ready_i`.
  - On transfer with no new last beat, `wx_valid_o <= 0`.
  - On transfer coinciding with an accepted last beat, `wx_valid_o` stays 1 and `wx_o` takes the new sum (back-to-back, full throughput).
- `clear_i`:
  - Next cycle: `pass_cnt = 0`, `wx_valid_o = 0`, `busy_o = 0`.
  - Any beat accepted in the same cycle is discarded; clear wins.
  - `psum_ready_o` is unaffected by `clear_i` during the clear cycle.
- `cfg_num_passes` changes mid-group have no effect until the next group starts.

## Timing
- Reset (`rst` high at a `clk` edge):
  - `pass_cnt = 0`, `acc = 0`, `wx_o = 0`, `wx_valid_o = 0`, `busy_o = 0`, `n_passes = 1`.
  - `psum_ready_o = 1` after reset.
- Reset mid-group or mid-stall drops all partial and pending data.
- Latency: `wx_valid_o` rises the cycle after the accepted last beat.
- Throughput: one psum beat per cycle when the scaler keeps `wx_ready_i` high. One output vector per N cycles.
- Stall: with `wx_valid_o=1` and `wx_ready_i=0`, the next group accumulates up to its last beat, then `psum_ready_o=0` until drain.
- `busy_o` is registered: high from the cycle after an accepted first beat of a group with N>1, until the cycle after its last beat.

## Test plan
- **Reset:** assert `rst` for 2 cycles mid-group.
  - Expect `wx_valid_o=0`, `wx_o=0`, `busy_o=0`, `psum_ready_o=1`.
  - A subsequent 1-pass beat of 7 yields `wx_o=7`.
- **Basic accumulate:** N=3, lane0 beats 100, −30, 5, `wx_ready_i=1`.
  - Expect `wx_o[0]=75`, `wx_valid_o` high exactly 1 cycle, one cycle after the third beat.
  - Test N=0 and N=1: each beat is emitted directly, one output per input.
- **Saturation:** EW=20, N=20, lane1 all 32767.
  - Expect `wx_o[1]=524287`; with all −32768, expect −524288.
  - Mixed beats crossing the limit and returning stay clamped from the crossing point.
- **Backpressure:** N=2, hold `wx_ready_i=0` after the first output.
  - Expect the next group's first beat accepted.
  - Expect `psum_ready_o=0` on its last beat.
  - Expect `wx_o` unchanged while stalled.
  - Raise `wx_ready_i`: the last beat is accepted the same cycle and the new sum appears next cycle with no bubble.
- **Back-to-back:** N=1, continuous valid and ready, 16 beats.
  - Expect 16 outputs on consecutive cycles matching inputs in order.
- **Clear:** N=4, assert `clear_i` after 2 beats, together with a third accepted beat.
  - Expect `busy_o=0`, no output.
  - The next 4 beats (1, 2, 3, 4) yield `wx_o=10`.
